// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add (optionally subtract with NIBBLE_ADD_SUB_EN) computed one nibble per clock
// through a single ripplecarry_adder4bit, with valid/ready handshakes on both sides.
module ripplecarry_adder4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, b_eff;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d, am_q, am_d, bm_q, bm_d;
  logic             c_in, co;
  logic [3:0]       s;
`ifdef NIBBLE_ADD_SUB_EN
  assign b_eff = op_sub ? ~b : b;
  assign c_in  = op_sub ? 1'b1 : cin;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  assign b_eff = b;
  assign c_in  = cin;
`endif
  ripplecarry_adder4bit u_add (.a(a_q[3:0]), .b(b_q[3:0]), .cin(c_q), .s(s), .cout(co));
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    am_d    = am_q;
    bm_d    = bm_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b_eff;
        c_d     = c_in;
        cnt_d   = '0;
        sum_d   = '0;
        am_d    = a[WIDTH-1];
        bm_d    = b_eff[WIDTH-1];
        state_d = RUN;
      end
      RUN: begin
        sum_d = WIDTH'({s, sum_q} >> 4);
        c_d   = co;
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NIB - 1)) begin
          state_d = DONE;
          cout_d  = co;
          ovf_d   = (am_q == bm_q) && (s[3] != am_q);
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      am_q    <= am_d;
      bm_q    <= bm_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed checks of the 16-bit nibble-serial adder.
module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        op_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;
  int          n_asrt = 0;
  int          n_fail = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [15:0] av, input logic [15:0] bv, input logic c, input logic sub);
    @(negedge clk);
    in_valid = 1'b1; a = av; b = bv; cin = c; op_sub = sub;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called on the negedge right after the acceptance edge; result must appear after edge 4.
  task automatic run_check(input string tag, input logic [15:0] es, input logic ec, input logic eo);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready_busy"}, 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    accept(16'h1234, 16'h4321, 1'b0, 1'b0);
    run_check("add1", 16'h5555, 1'b0, 1'b0);
    release_out("add1");

    accept(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_check("ripple", 16'h0000, 1'b1, 1'b0);
    release_out("ripple");

    accept(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_check("ovf", 16'h8000, 1'b0, 1'b1);
    release_out("ovf");

    accept(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    run_check("cin", 16'h0000, 1'b1, 1'b0);
    release_out("cin");

    accept(16'h1111, 16'h2222, 1'b0, 1'b0);
    run_check("bp", 16'h3333, 1'b0, 1'b0);
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h1111; cin = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_sum", 32'(sum), 32'h3333);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_valid", 32'(out_valid), 32'd0);
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    chk("bp_idle_sum", 32'(sum), 32'h3333);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_new_busy", 32'(busy), 32'd1);
    run_check("bp_new", 16'hBBBB, 1'b0, 1'b0);
    release_out("bp_new");

    accept(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    accept(16'h0001, 16'h0001, 1'b0, 1'b0);
    run_check("post_rst", 16'h0002, 1'b0, 1'b0);
    release_out("post_rst");

`ifdef NIBBLE_ADD_SUB_EN
    accept(16'h0005, 16'h0007, 1'b0, 1'b1);
    run_check("sub_neg", 16'hFFFE, 1'b0, 1'b0);
    release_out("sub_neg");
    accept(16'h8000, 16'h0001, 1'b0, 1'b1);
    run_check("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
    release_out("sub_ovf");
`else
    accept(16'h0005, 16'h0007, 1'b0, 1'b1);
    run_check("sub_ignored", 16'h000C, 1'b0, 1'b0);
    release_out("sub_ignored");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle wide adder that adds two WIDTH-bit operands one nibble per clock. It uses a single instance of the team's 4-bit ripple-carry adder cell, ripplecarry_adder4bit, and registers the carry between nibbles. The block has valid/ready handshakes on both sides and sits between operand-producing logic and result consumers that cannot afford a full-width combinational adder.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4; the count of nibbles is NIB = WIDTH/4.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
in_valid  input  1  operands a, b and cin are valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in to nibble 0.
op_sub  input  1  subtract request; used only when the macro is defined, otherwise ignored.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  result.
cout  output  1  carry out of bit WIDTH-1.
ovf  output  1  two's-complement overflow.
busy  output  1  high in RUN and DONE.

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is synchronous and active-low, sampled only on the rising edge of clk.
- Reset values: state=IDLE, out_valid=0, sum=0, cout=0, ovf=0, busy=0, nibble count=0, carry register=0, operand shift registers=0.
- in_ready = (state==IDLE). It is combinational from state and is 1 on the cycle after reset releases.
- IDLE:
  - On in_valid && in_ready, capture a into an A shift register and b into a B shift register.
  - Load carry register with cin.
  - Clear nibble count, clear sum, and go to RUN.
- RUN, one nibble per cycle:
  - Adder inputs: A[3:0], B[3:0], carry register.
  - Write the adder's 4-bit sum into sum, shifting sum right by 4 and inserting at [WIDTH-1:WIDTH-4]. After NIB cycles, nibble 0 is at [3:0].
  - Carry register <= adder cout.
  - Shift A and B right by 4.
  - Increment count.
  - On the cycle where count==NIB-1, go to DONE.
  - Latch cout <= adder cout and ovf <= (a_msb == b_eff_msb) && (sum_msb != a_msb). a_msb and b_eff_msb are captured at acceptance.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable.
  - On out_ready, go to IDLE and drop out_valid on the next edge. The result registers keep their value until the next run starts.
- Latency: out_valid rises exactly NIB clock edges after the acceptance edge (16-bit: 4 cycles). Throughput is one operation per NIB+2 cycles minimum.
- Back-pressure: out_ready low holds DONE indefinitely. in_valid is ignored while busy, with no queuing.
- Carry ripples across nibbles only through the carry register. The full-width result equals (a + b + cin) mod 2^WIDTH, and cout is bit WIDTH of the true sum.
- Boundary cases:
  - WIDTH=4: RUN lasts one cycle.
  - All-ones + 1 ripples through every nibble and gives cout=1.
- Reset mid-operation (RUN or DONE): the operation is discarded with no partial output. Registers take reset values and out_valid is 0 on the following cycle.
- Simultaneous out_ready and in_valid in DONE: only the result is consumed. New operands are accepted no earlier than the next cycle (in IDLE).

Optional Feature:
Macro: NIBBLE_ADD_SUB_EN.
- Defined:
  - When op_sub=1 at acceptance, the B shift register loads ~b and the carry register loads 1 (cin ignored), so result = a - b mod 2^WIDTH.
  - cout=1 means no borrow.
  - b_eff_msb = ~b[WIDTH-1].
  - op_sub=0 behaves as plain addition.
- Undefined: op_sub is ignored, the block is addition-only, and b_eff_msb = b[WIDTH-1].

Test Plan (WIDTH=16):
- a=0x1234, b=0x4321, cin=0 -> out_valid exactly 4 edges after acceptance; sum=0x5555, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry through all 4 nibbles). Also a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1; in_ready=0 for all cycles from acceptance until out_ready handshake.
- out_ready held low 6 cycles in DONE while in_valid=1 with new operands -> out_valid and sum stable, in_ready=0, new operands not captured. Raise out_ready -> IDLE next cycle, then new operands accepted.
- rst_n driven low for one edge after 2 RUN cycles -> next cycle out_valid=0, sum=0, busy=0, in_ready=1; a fresh add of 0x0001+0x0001 then gives 0x0002.
- With NIBBLE_ADD_SUB_EN: 0x0005-0x0007 (op_sub=1) -> sum=0xFFFE, cout=0, ovf=0; 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1. Without the macro, op_sub=1 on 0x0005,0x0007 -> sum=0x000C.
